// File: rtl/unsigned_mul_8x8_pkg.sv
// rtl/unsigned_mul_8x8_pkg.sv - shared widths and row-weighting helper for the 8x8 HA accumulator
package unsigned_mul_8x8_pkg;

  localparam int HA_T_W  = 9;
  localparam int HA_B_W  = 7;
  localparam int HA_ROWS = 4;
  localparam int ROW_W   = 11;
  localparam int PAIR_W  = 13;

  // Bottom (carry) bits sit two places above their top-row partners.
  function automatic logic [ROW_W-1:0] row_value(input logic [HA_T_W-1:0] t,
                                                 input logic [HA_B_W-1:0] b);
    return {2'b00, t} + {b, 2'b00};
  endfunction

endpackage

// File: rtl/ha_row_pair_add.sv
// rtl/ha_row_pair_add.sv - combines two adjacent half-adder rows into one 13-bit partial sum
module ha_row_pair_add
  import unsigned_mul_8x8_pkg::*;
(
  input  logic [HA_T_W-1:0] t_a,
  input  logic [HA_B_W-1:0] b_a,
  input  logic [HA_T_W-1:0] t_b,
  input  logic [HA_B_W-1:0] b_b,
  output logic [PAIR_W-1:0] pair_sum
);

  logic [ROW_W-1:0] row_a;
  logic [ROW_W-1:0] row_b;

  always_comb begin
    row_a    = row_value(t_a, b_a);
    row_b    = row_value(t_b, b_b);
    pair_sum = {2'b00, row_a} + {row_b, 2'b00};
  end

endmodule

// File: rtl/unsigned_mul_8x8_ha_accum_pipe.sv
// rtl/unsigned_mul_8x8_ha_accum_pipe.sv - two-stage valid/ready accumulator of four HA rows
module unsigned_mul_8x8_ha_accum_pipe
  import unsigned_mul_8x8_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HA_T_W-1:0] ha_array_0_t,
  input  logic [HA_T_W-1:0] ha_array_1_t,
  input  logic [HA_T_W-1:0] ha_array_2_t,
  input  logic [HA_T_W-1:0] ha_array_3_t,
  input  logic [HA_B_W-1:0] ha_array_0_b,
  input  logic [HA_B_W-1:0] ha_array_1_b,
  input  logic [HA_B_W-1:0] ha_array_2_b,
  input  logic [HA_B_W-1:0] ha_array_3_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  product
);

  logic [PAIR_W-1:0] s01_new;
  logic [PAIR_W-1:0] s23_new;

  logic              s1_valid_q, s1_valid_d;
  logic [PAIR_W-1:0] s01_q, s01_d;
  logic [PAIR_W-1:0] s23_q, s23_d;
  logic              s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0]  product_q, product_d;

  logic              s1_adv;
  logic              s2_adv;

  ha_row_pair_add u_pair01 (
    .t_a      (ha_array_0_t),
    .b_a      (ha_array_0_b),
    .t_b      (ha_array_1_t),
    .b_b      (ha_array_1_b),
    .pair_sum (s01_new)
  );

  ha_row_pair_add u_pair23 (
    .t_a      (ha_array_2_t),
    .b_a      (ha_array_2_b),
    .t_b      (ha_array_3_t),
    .b_b      (ha_array_3_b),
    .pair_sum (s23_new)
  );

  always_comb begin
    s2_adv = !s2_valid_q || out_ready;
    s1_adv = !s1_valid_q || s2_adv;

    s1_valid_d = s1_valid_q;
    s01_d      = s01_q;
    s23_d      = s23_q;
    s2_valid_d = s2_valid_q;
    product_d  = product_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s01_d = s01_new;
        s23_d = s23_new;
      end
    end

    // Truncating each operand before the add is exact modulo 2^OUT_W.
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        product_d = OUT_W'(s01_q) + (OUT_W'(s23_q) << 4);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s01_q      <= '0;
      s23_q      <= '0;
      s2_valid_q <= 1'b0;
      product_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s01_q      <= s01_d;
      s23_q      <= s23_d;
      s2_valid_q <= s2_valid_d;
      product_q  <= product_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign product   = product_q;

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_accum_pipe.sv
// tb/tb_unsigned_mul_8x8_ha_accum_pipe.sv - directed and random checks for the HA accumulator pipe
module tb_unsigned_mul_8x8_ha_accum_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [8:0] t [4];
  logic [6:0] b [4];

  logic        in_ready, out_valid, in_ready18, out_valid18;
  logic [15:0] product;
  logic [17:0] product18;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  unsigned_mul_8x8_ha_accum_pipe #(.OUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ha_array_0_t(t[0]), .ha_array_1_t(t[1]), .ha_array_2_t(t[2]), .ha_array_3_t(t[3]),
    .ha_array_0_b(b[0]), .ha_array_1_b(b[1]), .ha_array_2_b(b[2]), .ha_array_3_b(b[3]),
    .out_valid(out_valid), .out_ready(out_ready), .product(product)
  );

  unsigned_mul_8x8_ha_accum_pipe #(.OUT_W(18)) dut18 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready18),
    .ha_array_0_t(t[0]), .ha_array_1_t(t[1]), .ha_array_2_t(t[2]), .ha_array_3_t(t[3]),
    .ha_array_0_b(b[0]), .ha_array_1_b(b[1]), .ha_array_2_b(b[2]), .ha_array_3_b(b[3]),
    .out_valid(out_valid18), .out_ready(out_ready), .product(product18)
  );

  function automatic int model_full();
    int s = 0;
    for (int k = 0; k < 4; k++) s += (int'(t[k]) + 4 * int'(b[k])) << (2 * k);
    return s;
  endfunction

  task automatic clear_rows();
    for (int k = 0; k < 4; k++) begin
      t[k] = '0;
      b[k] = '0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++;
    if (product !== 16'd0) begin errors++; $display("FAIL reset_product got %0d want 0", product); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    @(negedge clk);
    clear_rows();
    t[0] = 9'd1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_first_accept in_ready got %0b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early out_valid got %0b want 0", out_valid); end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || product !== 16'd1)
      begin errors++; $display("FAIL lat_result valid %0b product %0d want 1/1", out_valid, product); end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_drain out_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_top_weight();
    @(negedge clk);
    clear_rows();
    b[3] = 7'h40;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || product !== 16'd16384)
      begin errors++; $display("FAIL top_weight valid %0b product %0d want 1/16384", out_valid, product); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      t[k] = 9'h1FF;
      b[k] = 7'h7F;
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || product !== 16'd21079)
      begin errors++; $display("FAIL wrap16 valid %0b product %0d want 1/21079", out_valid, product); end
    checks++;
    if (out_valid18 !== 1'b1 || product18 !== 18'd86615)
      begin errors++; $display("FAIL wrap18 valid %0b product %0d want 1/86615", out_valid18, product18); end
  endtask

  task automatic test_stall();
    int expq[$];
    int accepted = 0;
    int emitted = 0;
    bit saw_drop = 0;
    bit prev_hold = 0;
    logic [15:0] prev_prod = '0;
    int exp_v;
    for (int cyc = 0; cyc < 30 && emitted < 4; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 2 && cyc <= 4);
      in_valid = (accepted < 4);
      clear_rows();
      t[0] = 9'(accepted * 37 + 5);
      b[1] = 7'(accepted + 3);
      t[3] = 9'(accepted * 100);
      #1;
      if (prev_hold) begin
        checks++;
        if (out_valid !== 1'b1 || product !== prev_prod)
          begin errors++; $display("FAIL stall_hold valid %0b product %0d want 1/%0d", out_valid, product, prev_prod); end
      end
      if (!in_ready && !saw_drop) begin
        saw_drop = 1;
        checks++;
        if (accepted - emitted != 2)
          begin errors++; $display("FAIL stall_buffered got %0d want 2", accepted - emitted); end
      end
      if (out_valid && out_ready) begin
        exp_v = (expq.size() > 0) ? expq.pop_front() : -1;
        checks++;
        if (exp_v < 0 || product !== 16'(exp_v))
          begin errors++; $display("FAIL stall_order product %0d want %0d", product, exp_v); end
        emitted++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(model_full());
        accepted++;
      end
      prev_hold = out_valid && !out_ready;
      prev_prod = product;
    end
    in_valid = 1'b0;
    checks++;
    if (emitted != 4 || !saw_drop)
      begin errors++; $display("FAIL stall_complete emitted %0d drop %0b want 4/1", emitted, saw_drop); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    clear_rows();
    t[1] = 9'd7;
    @(negedge clk);
    t[2] = 9'd9;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre out_valid got %0b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || product !== 16'd0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL rst_mid valid %0b product %0d ready %0b want 0/0/1", out_valid, product, in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale out_valid got %0b want 0", out_valid); end
    end
  endtask

  task automatic test_random();
    int expq[$];
    int n = 0;
    int cyc = 0;
    int exp_v;
    bit prev_hold = 0;
    logic [15:0] prev_prod = '0;
    while (n < 10000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) begin
        t[k] = 9'($urandom());
        b[k] = 7'($urandom());
      end
      #1;
      if (prev_hold) begin
        checks++;
        if (out_valid !== 1'b1 || product !== prev_prod)
          begin errors++; $display("FAIL rand_hold valid %0b product %0d want 1/%0d", out_valid, product, prev_prod); end
      end
      if (out_valid && out_ready) begin
        exp_v = (expq.size() > 0) ? expq.pop_front() : -1;
        checks++;
        if (exp_v < 0 || product !== 16'(exp_v) || product18 !== 18'(exp_v))
          begin errors++; $display("FAIL rand_product got %0d/%0d want %0d", product, product18, exp_v); end
        n++;
      end
      if (in_valid && in_ready) expq.push_back(model_full());
      prev_hold = out_valid && !out_ready;
      prev_prod = product;
    end
    in_valid = 1'b0;
    checks++;
    if (n < 10000) begin errors++; $display("FAIL rand_timeout transfers %0d want 10000", n); end
  endtask

  initial begin
    clear_rows();
    test_reset();
    test_latency();
    test_top_weight();
    test_wrap();
    test_stall();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
